// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to
// instruction memory and presents the returned word to the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic        IMemValid,
  input  logic [31:0] IMemData,
  input  logic        NotStall,
  input  logic        Flush,
  input  logic [31:0] BranchTarget,
  output logic [31:0] Instruction_IF,
  output logic [31:0] PC_IF,
  output logic [31:0] PCAdderResult_IF,
  output logic        Valid_IF
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   fetch_pc, fetch_pc_n;
  logic [DATA_W-1:0]   req_pc, req_pc_n;
  logic [DATA_W-1:0]   instr_p0, instr_p0_n;
  logic [DATA_W-1:0]   pc_p0, pc_p0_n;
  logic [DATA_W-1:0]   pc_add_p0, pc_add_p0_n;
  logic                vld_p0, vld_p0_n;
  logic                outstanding_after;

  // Unsigned 32-bit PC increment; wraps from 32'hFFFF_FFFC to 0.
  function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(4);
  endfunction

  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    req_pc_n    = req_pc;
    instr_p0_n  = instr_p0;
    pc_p0_n     = pc_p0;
    pc_add_p0_n = pc_add_p0;
    vld_p0_n    = vld_p0;

    case (state)
      S_FETCH: begin
        if (IMemReady) begin
          req_pc_n   = fetch_pc;
          fetch_pc_n = pc_inc(fetch_pc);
          state_n    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (IMemValid) begin
          instr_p0_n  = IMemData;
          pc_p0_n     = req_pc;
          pc_add_p0_n = pc_inc(req_pc);
          vld_p0_n    = 1'b1;
          state_n     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (NotStall) begin
          vld_p0_n   = 1'b0;
          instr_p0_n = NOP_INSTR;
          state_n    = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (IMemValid) begin
          state_n = S_FETCH;
        end
      end
      default: state_n = S_FETCH;
    endcase

    // A redirect must still swallow any response that is owed to an
    // already-accepted request, otherwise it would be taken as the target's.
    outstanding_after = ((state == S_FETCH) && IMemReady) ||
                        ((state == S_WAIT)  && !IMemValid) ||
                        ((state == S_DRAIN) && !IMemValid);

    if (Flush) begin
      fetch_pc_n = BranchTarget;
      vld_p0_n   = 1'b0;
      instr_p0_n = NOP_INSTR;
      state_n    = outstanding_after ? S_DRAIN : S_FETCH;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_FETCH;
      fetch_pc  <= RESET_PC;
      req_pc    <= RESET_PC;
      instr_p0  <= NOP_INSTR;
      pc_p0     <= '0;
      pc_add_p0 <= '0;
      vld_p0    <= 1'b0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      req_pc    <= req_pc_n;
      instr_p0  <= instr_p0_n;
      pc_p0     <= pc_p0_n;
      pc_add_p0 <= pc_add_p0_n;
      vld_p0    <= vld_p0_n;
    end
  end

  assign IMemReq          = (state == S_FETCH);
  assign IMemAddr         = fetch_pc;
  assign Instruction_IF   = instr_p0;
  assign PC_IF            = pc_p0;
  assign PCAdderResult_IF = pc_add_p0;
  assign Valid_IF         = vld_p0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed scenarios, a latency-programmable
// memory responder, and a monitor checking requests and consumed instructions.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic        IMemValid;
  logic [31:0] IMemData;
  logic        NotStall;
  logic        Flush;
  logic [31:0] BranchTarget;
  logic [31:0] Instruction_IF;
  logic [31:0] PC_IF;
  logic [31:0] PCAdderResult_IF;
  logic        Valid_IF;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] add;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          rem;
  } pend_t;

  exp_t        iq[$];
  logic [31:0] aq[$];
  pend_t       pq[$];

  if_fetch_unit #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .IMemReq         (IMemReq),
    .IMemAddr        (IMemAddr),
    .IMemReady       (IMemReady),
    .IMemValid       (IMemValid),
    .IMemData        (IMemData),
    .NotStall        (NotStall),
    .Flush           (Flush),
    .BranchTarget    (BranchTarget),
    .Instruction_IF  (Instruction_IF),
    .PC_IF           (PC_IF),
    .PCAdderResult_IF(PCAdderResult_IF),
    .Valid_IF        (Valid_IF)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h3C01_1234;
      32'h0000_0008: return 32'hDEAD_BEEF;
      32'h0000_0100: return 32'h8C22_0004;
      32'h0000_0200: return 32'hAC43_0008;
      32'hFFFF_FFFC: return 32'h0800_0040;
      default:       return a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic accept_one();
    bit got = 0;
    IMemReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (IMemReq) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_now("accept_timeout");
    @(posedge Clk);
    #1;
    IMemReady = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (Valid_IF) break;
      tick();
    end
    chk("wait_valid", Valid_IF, 1'b1);
  endtask

  // Memory responder: each accepted request answered rem cycles later.
  initial begin
    bit          acc;
    logic [31:0] acc_addr;
    IMemValid = 1'b0;
    IMemData  = '0;
    forever begin
      @(negedge Clk);
      acc      = IMemReq && IMemReady && !Reset;
      acc_addr = IMemAddr;
      @(posedge Clk);
      #1;
      foreach (pq[i]) pq[i].rem--;
      if (acc) pq.push_back('{acc_addr, mem_lat});
      IMemValid = 1'b0;
      IMemData  = '0;
      if (pq.size() > 0 && pq[0].rem <= 1) begin
        IMemValid = 1'b1;
        IMemData  = mem_word(pq[0].addr);
        void'(pq.pop_front());
      end
    end
  end

  // Monitor: accepted requests and consumed instructions against the queues.
  initial begin
    exp_t        e;
    logic [31:0] ea;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        if (IMemReq && IMemReady) begin
          if (aq.size() == 0) fail_now("unexpected_request");
          else begin
            ea = aq.pop_front();
            chk("req_addr", IMemAddr, ea);
          end
        end
        if (Valid_IF && NotStall && !Flush) begin
          if (iq.size() == 0) fail_now("unexpected_instr");
          else begin
            e = iq.pop_front();
            chk("sb_instr", Instruction_IF, e.instr);
            chk("sb_pc", PC_IF, e.pc);
            chk("sb_pc_add", PCAdderResult_IF, e.add);
          end
        end
      end
      if (!Valid_IF) chk("bubble_nop", Instruction_IF, NOP);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset        = 1'b1;
    IMemReady    = 1'b0;
    NotStall     = 1'b0;
    Flush        = 1'b0;
    BranchTarget = '0;
    tick();
    tick();
    chk("rst_valid", Valid_IF, 1'b0);
    chk("rst_instr", Instruction_IF, NOP);
    chk("rst_pc", PC_IF, 32'h0);
    chk("rst_pc_add", PCAdderResult_IF, 32'h0);
    chk("rst_req", IMemReq, 1'b1);
    chk("rst_addr", IMemAddr, RESET_PC);
    Reset = 1'b0;
    tick();

    // First fetch, 1-cycle memory, consumed immediately
    aq.push_back(32'h0);
    iq.push_back('{32'h2008_0005, 32'h0, 32'h4});
    mem_lat  = 1;
    NotStall = 1'b1;
    accept_one();
    wait_valid();
    chk("s1_instr", Instruction_IF, 32'h2008_0005);
    chk("s1_pc", PC_IF, 32'h0);
    chk("s1_pc_add", PCAdderResult_IF, 32'h4);
    tick();
    chk("s1_consumed", Valid_IF, 1'b0);
    chk("s1_next_req", IMemReq, 1'b1);
    chk("s1_next_addr", IMemAddr, 32'h4);

    // Memory not ready for 3 cycles
    NotStall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2_req_held", IMemReq, 1'b1);
      chk("s2_addr_held", IMemAddr, 32'h4);
    end
    aq.push_back(32'h4);
    accept_one();

    // Held by ID stall for 4 cycles, then consumed
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s3_hold_instr", Instruction_IF, 32'h3C01_1234);
      chk("s3_hold_pc", PC_IF, 32'h4);
      chk("s3_hold_valid", Valid_IF, 1'b1);
      chk("s3_hold_noreq", IMemReq, 1'b0);
    end
    iq.push_back('{32'h3C01_1234, 32'h4, 32'h8});
    NotStall = 1'b1;
    tick();
    NotStall = 1'b0;
    chk("s3_consumed", Valid_IF, 1'b0);
    chk("s3_next_req", IMemReq, 1'b1);
    chk("s3_next_addr", IMemAddr, 32'h8);

    // Flush while WAIT, stale response arrives later and is discarded
    aq.push_back(32'h8);
    mem_lat = 3;
    accept_one();
    Flush        = 1'b1;
    BranchTarget = 32'h0000_0100;
    tick();
    Flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (IMemReq) break;
      chk("s4_drain_valid", Valid_IF, 1'b0);
      tick();
    end
    chk("s4_refetch_req", IMemReq, 1'b1);
    chk("s4_refetch_addr", IMemAddr, 32'h100);
    chk("s4_valid_after", Valid_IF, 1'b0);

    // Flush with NotStall in HOLD drops the held instruction
    aq.push_back(32'h100);
    mem_lat = 1;
    accept_one();
    wait_valid();
    chk("s5_instr", Instruction_IF, 32'h8C22_0004);
    chk("s5_pc", PC_IF, 32'h100);
    chk("s5_pc_add", PCAdderResult_IF, 32'h104);
    Flush        = 1'b1;
    BranchTarget = 32'h0000_0200;
    NotStall     = 1'b1;
    tick();
    Flush    = 1'b0;
    NotStall = 1'b0;
    chk("s5_drop_valid", Valid_IF, 1'b0);
    chk("s5_drop_instr", Instruction_IF, NOP);
    chk("s5_target_req", IMemReq, 1'b1);
    chk("s5_target_addr", IMemAddr, 32'h200);

    // Flush coinciding with the response in WAIT: no DRAIN
    aq.push_back(32'h200);
    mem_lat = 2;
    accept_one();
    tick();
    Flush        = 1'b1;
    BranchTarget = 32'hFFFF_FFFC;
    tick();
    Flush = 1'b0;
    chk("s6_no_drain_req", IMemReq, 1'b1);
    chk("s6_target_addr", IMemAddr, 32'hFFFF_FFFC);
    chk("s6_valid", Valid_IF, 1'b0);

    // PC wrap at the top of the address space
    aq.push_back(32'hFFFF_FFFC);
    iq.push_back('{32'h0800_0040, 32'hFFFF_FFFC, 32'h0});
    mem_lat  = 1;
    NotStall = 1'b1;
    accept_one();
    wait_valid();
    chk("s7_pc", PC_IF, 32'hFFFF_FFFC);
    chk("s7_pc_add_wrap", PCAdderResult_IF, 32'h0);
    tick();
    NotStall = 1'b0;
    chk("s7_wrap_req", IMemReq, 1'b1);
    chk("s7_wrap_addr", IMemAddr, 32'h0);

    // Reset mid-WAIT; late response must be ignored
    aq.push_back(32'h0);
    mem_lat = 3;
    accept_one();
    chk("s8_in_wait", IMemReq, 1'b0);
    Reset = 1'b1;
    #1;
    chk("s8_async_req", IMemReq, 1'b1);
    chk("s8_async_addr", IMemAddr, RESET_PC);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s8_ignore_valid", Valid_IF, 1'b0);
      chk("s8_req", IMemReq, 1'b1);
      chk("s8_addr", IMemAddr, RESET_PC);
    end
    aq.push_back(32'h0);
    iq.push_back('{32'h2008_0005, 32'h0, 32'h4});
    mem_lat  = 1;
    NotStall = 1'b1;
    accept_one();
    wait_valid();
    chk("s8_instr", Instruction_IF, 32'h2008_0005);
    tick();
    NotStall = 1'b0;
    tick();

    chk("addr_queue_empty", aq.size(), 0);
    chk("instr_queue_empty", iq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the IF-side inputs of the IF/ID pipeline register: Instruction_IF, PC_IF and PCAdderResult_IF.
- Owns the program counter and runs a single-outstanding request/response handshake with instruction memory.
- Holds its output while ID stalls (NotStall=0).
- On a branch/jump redirect (Flush) it discards stale fetches and restarts at the target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word driven on Instruction_IF whenever no valid instruction is presented.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IMemReq  out  1  fetch request valid.
- IMemAddr  out  32  fetch address; equals fetch_pc while IMemReq=1.
- IMemReady  in  1  memory accepts the request this cycle when IMemReq=1.
- IMemValid  in  1  response valid (one response per accepted request).
- IMemData  in  32  response instruction word.
- NotStall  in  1  ID side accepts the presented instruction this cycle.
- Flush  in  1  redirect request from the branch/jump resolution logic.
- BranchTarget  in  32  redirect PC, sampled when Flush=1.
- Instruction_IF  out  32  presented instruction; NOP_INSTR when Valid_IF=0.
- PC_IF  out  32  address of the presented instruction.
- PCAdderResult_IF  out  32  PC_IF + 4, modulo 2^32.
- Valid_IF  out  1  presented instruction is valid.

Behaviour:
Reset:
- fetch_pc=RESET_PC, state=FETCH, Valid_IF=0, Instruction_IF=NOP_INSTR, PC_IF=0, PCAdderResult_IF=0.
- Reset has immediate effect mid-operation. Any response in flight at reset is ignored, because IMemValid is ignored in FETCH.

States:
- FETCH:
  - IMemReq=1, IMemAddr=fetch_pc.
  - If IMemReady=1: req_pc <= fetch_pc; fetch_pc <= fetch_pc+4; go to WAIT.
  - If IMemReady=0: stay in FETCH.
- WAIT:
  - IMemReq=0.
  - On IMemValid=1: Instruction_IF <= IMemData, PC_IF <= req_pc, PCAdderResult_IF <= req_pc+4, Valid_IF <= 1; go to HOLD.
  - Response latency is at least 1 cycle after acceptance and is otherwise unbounded.
- HOLD:
  - IMemReq=0; outputs are held stable.
  - If NotStall=1 (consume): Valid_IF <= 0, Instruction_IF <= NOP_INSTR; go to FETCH.
  - If NotStall=0: stay in HOLD with all outputs unchanged.
- DRAIN:
  - IMemReq=0, Valid_IF=0.
  - On IMemValid=1: discard IMemData; go to FETCH.

Flush (highest priority after Reset, evaluated in every state):
- fetch_pc <= BranchTarget; Valid_IF <= 0; Instruction_IF <= NOP_INSTR.
- Next state:
  - DRAIN if a request is outstanding after this edge: state is WAIT with IMemValid=0, or state is FETCH with IMemReady=1 this cycle.
  - FETCH otherwise, including WAIT with IMemValid=1 this cycle, where the response is dropped.
- In DRAIN, a second Flush only updates fetch_pc and stays in DRAIN.
- Flush in HOLD overrides NotStall; the held instruction is dropped.

Timing and arithmetic:
- Peak throughput is one instruction per 3 cycles with single-cycle memory (FETCH→WAIT→HOLD consumed).
- This design deliberately allows only one outstanding request and has no skid buffer.
- All PC arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC + 4 = 0.
- No alignment check is performed; BranchTarget is used as given.
- PC_IF and PCAdderResult_IF may hold stale values while Valid_IF=0. Instruction_IF must be NOP_INSTR so the IF/ID register latches a bubble.

Test Plan:
- Reset release, IMemReady=1, 1-cycle memory returning 32'h2008_0005 at address 0, NotStall=1 → IMemAddr=0, then Valid_IF=1, Instruction_IF=32'h2008_0005, PC_IF=0, PCAdderResult_IF=4; next IMemAddr=4.
- IMemReady held 0 for 3 cycles in FETCH → IMemReq stays 1, IMemAddr stays 4, fetch_pc unchanged; advances to 8 only after IMemReady=1.
- Instruction held with NotStall=0 for 4 cycles → Instruction_IF, PC_IF, Valid_IF stable, IMemReq=0; NotStall=1 → Valid_IF=0 next cycle and a request to the next PC.
- Flush with BranchTarget=32'h0000_0100 while WAIT, response arriving 2 cycles later with 32'hDEAD_BEEF → response discarded, Valid_IF stays 0, next IMemAddr=32'h100.
- Flush and NotStall=1 together in HOLD → held instruction dropped, Valid_IF=0, Instruction_IF=NOP_INSTR, next fetch at BranchTarget; Flush in the same cycle as IMemValid in WAIT → data dropped, no DRAIN state.
- fetch_pc=32'hFFFF_FFFC → PCAdderResult_IF=0 and next IMemAddr=0; Reset asserted mid-WAIT, then a late IMemValid → ignored, first request goes to RESET_PC.
